// File: rtl/program_loader.sv
// Boot loader: fills program RAM over the shared bus (address, data, write per byte), then enables the CPU.
// Four cycles minimum per byte. Waits in WAIT_BYTE with byte_ready high until byte_valid arrives.
module program_loader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_req,
    input  logic              go,
    input  logic              abort,
    input  logic [DATA_W-1:0] byte_in,
    input  logic              byte_valid,
    input  logic              byte_last,
    output logic              byte_ready,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_drive,
    output logic              ctrl_override,
    output logic              n_lma,
    output logic              n_lmd,
    output logic              n_lr,
    output logic              cpu_run,
    output logic              load_done,
    output logic              len_full,
    output logic [ADDR_W:0]   bytes_written
);

    typedef enum logic [2:0] {
        IDLE, WAIT_BYTE, ADDR, DATA, WRITE, RUN
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   byte_q, byte_d;
    logic                last_q, last_d;
    logic [DATA_W-1:0]   bus_out_q, bus_out_d;
    logic                load_done_q, load_done_d;
    logic                len_full_q, len_full_d;
    logic [ADDR_W:0]     bw_q, bw_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            byte_q      <= '0;
            last_q      <= 1'b0;
            bus_out_q   <= '0;
            load_done_q <= 1'b0;
            len_full_q  <= 1'b0;
            bw_q        <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            byte_q      <= byte_d;
            last_q      <= last_d;
            bus_out_q   <= bus_out_d;
            load_done_q <= load_done_d;
            len_full_q  <= len_full_d;
            bw_q        <= bw_d;
        end
    end

    // bus_out is loaded on entry to ADDR/DATA so it is valid for the whole strobe cycle
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        byte_d      = byte_q;
        last_d      = last_q;
        bus_out_d   = '0;
        load_done_d = 1'b0;
        len_full_d  = len_full_q;
        bw_d        = bw_q;
        unique case (state_q)
            IDLE, RUN: begin
                if (load_req) begin
                    state_d    = WAIT_BYTE;
                    addr_d     = '0;
                    bw_d       = '0;
                    len_full_d = 1'b0;
                end else if (go && state_q == IDLE) begin
                    state_d = RUN;
                end
            end
            WAIT_BYTE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (byte_valid) begin
                    byte_d    = byte_in;
                    last_d    = byte_last;
                    bus_out_d = DATA_W'(addr_q);
                    state_d   = ADDR;
                end
            end
            ADDR: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    bus_out_d = byte_q;
                    state_d   = DATA;
                end
            end
            DATA: state_d = abort ? IDLE : WRITE;
            WRITE: begin
                bw_d = bw_q + (ADDR_W+1)'(1);
                if (abort) begin
                    state_d = IDLE;
                end else if (last_q) begin
                    state_d     = RUN;
                    load_done_d = 1'b1;
                end else if (addr_q == ADDR_W'(DEPTH-1)) begin
                    state_d     = RUN;
                    load_done_d = 1'b1;
                    len_full_d  = 1'b1;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = WAIT_BYTE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign byte_ready    = (state_q == WAIT_BYTE);
    assign bus_drive     = (state_q == ADDR) || (state_q == DATA);
    assign n_lma         = (state_q != ADDR);
    assign n_lmd         = (state_q != DATA);
    assign n_lr          = (state_q != WRITE);
    assign ctrl_override = (state_q == WAIT_BYTE) || (state_q == ADDR) ||
                           (state_q == DATA) || (state_q == WRITE);
    assign cpu_run       = (state_q == RUN);
    assign bus_out       = bus_out_q;
    assign load_done     = load_done_q;
    assign len_full      = len_full_q;
    assign bytes_written = bw_q;

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot-time controller that fills the 16-byte program RAM from the chip's dedicated input pins, then releases the CPU to run.
- Owns the shared 8-bit bus and the MAR/RAM load strobes while loading. Sequences address-load, data-load and RAM-write for each received byte.
- Holds the control block and program counter idle, through cpu_run, until loading completes.
- Replaces the tied-off input-to-bus tri-state path in the CPU top level.

Parameters:
ADDR_W, 4, RAM address width
DATA_W, 8, bus and byte width
DEPTH, 16, number of RAM bytes; maximum program length

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
load_req  in  1  start a load; takes priority over go
go  in  1  run the existing RAM contents without loading
abort  in  1  cancel the load in progress
byte_in  in  DATA_W  program byte from the input pins
byte_valid  in  1  byte_in is valid
byte_last  in  1  qualifies byte_in as the final program byte
byte_ready  out  1  loader accepts a byte this cycle
bus_out  out  DATA_W  value the loader drives onto the bus
bus_drive  out  1  loader tri-state enable for the bus (active-high)
ctrl_override  out  1  loader owns the bus and the RAM strobes; CPU control lines are gated off
n_lma  out  1  MAR address-load strobe (active-low)
n_lmd  out  1  MAR data-load strobe (active-low)
n_lr  out  1  RAM write strobe (active-low)
cpu_run  out  1  1 = control block and program counter may run
load_done  out  1  one-cycle pulse when a load completes
len_full  out  1  last load ended on DEPTH with no byte_last
bytes_written  out  ADDR_W+1  number of bytes written by the last or current load

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, address counter=0, bytes_written=0.
  - Outputs: byte_ready=0, bus_drive=0, bus_out=0, n_lma=n_lmd=n_lr=1, ctrl_override=0, cpu_run=0, load_done=0, len_full=0.
- Output decoding: all strobes, bus_drive, byte_ready and ctrl_override decode from the state register only (Moore). bus_out, load_done, len_full and bytes_written are registered.
- States: IDLE, WAIT_BYTE, ADDR, DATA, WRITE, RUN. ctrl_override=1 in WAIT_BYTE, ADDR, DATA and WRITE.
- IDLE:
  - load_req=1 -> WAIT_BYTE; clear the address counter, bytes_written and len_full.
  - Else go=1 -> RUN.
- WAIT_BYTE:
  - byte_ready=1.
  - On byte_valid=1, capture byte_in and byte_last -> ADDR.
  - byte_valid may stay low indefinitely.
- ADDR: bus_drive=1, bus_out = zero-extended address counter, n_lma=0 -> DATA.
- DATA: bus_drive=1, bus_out = captured byte, n_lmd=0 -> WRITE.
- WRITE:
  - n_lr=0, bus_drive=0; bytes_written increments at the end of the cycle.
  - If the captured last flag=1: -> RUN, pulse load_done.
  - Else if address counter = DEPTH-1: -> RUN, pulse load_done, set len_full=1.
  - Else: address counter +1 -> WAIT_BYTE.
- RUN:
  - cpu_run=1; all strobes inactive; bus_drive=0.
  - load_req=1 -> WAIT_BYTE with the same clears as IDLE; cpu_run drops in the next cycle.
  - go is ignored in RUN.
- Throughput: minimum 4 cycles per byte (WAIT_BYTE with valid, ADDR, DATA, WRITE).
- abort=1 in WAIT_BYTE, ADDR or DATA: -> IDLE next cycle; no n_lr pulse for the pending byte.
- abort=1 in WRITE: the write in that cycle still completes (bytes_written increments), then -> IDLE, no load_done.
- abort in IDLE or RUN: ignored.
- load_req and go asserted together in IDLE: load_req wins.
- Reset in any state: immediate return to the reset values. A RAM write interrupted by reset is undefined and is not retried.
- Address counter never wraps: a load cannot exceed DEPTH bytes.

Test Plan:
- Reset values: assert rst_n=0 mid-ADDR -> strobes all 1, bus_drive=0, cpu_run=0 asynchronously; state IDLE after release.
- Basic load: load_req, then bytes 0x1E, 0x2F, 0xE0 (last on the third), valid every cycle -> strobes in the sequence n_lma, n_lmd, n_lr per byte with bus_out 0x00/0x1E, 0x01/0x2F, 0x02/0xE0; RAM[0..2] match; load_done one cycle; bytes_written=3; cpu_run=1; len_full=0.
- Full program: 16 bytes 0x00..0x0F, no byte_last -> load ends after the 16th write, len_full=1, bytes_written=16, RAM[i]=i.
- Backpressure: insert 0-5 idle cycles between bytes -> byte_ready high only in WAIT_BYTE; no strobe fires while waiting; RAM contents are correct.
- Abort: abort in DATA of byte 2 -> no n_lr for byte 2, IDLE, bytes_written=1, cpu_run=0. Abort in WRITE of byte 2 -> bytes_written=2, no load_done.
- Priority and reload: load_req=go=1 in IDLE -> WAIT_BYTE. In RUN, go is ignored; load_req -> cpu_run=0 next cycle and a fresh load starts at address 0.
